keccak_rc_seq: RTL

Sequential Keccak-p round-constant generator, parametrised in lane width and round count. It replaces table lookup with the 8-bit LFSR form of rc(t): x^8+x^6+x^5+x^4+1. It sits beside the permutation round datapath. It steps through the rounds under a start/advance handshake and flags the last round, so the round controller needs no separate counter.

---
 rtl/keccak_pkg.sv | 48 ++++
 rtl/keccak_rc_seq_if.sv | 25 ++
 rtl/keccak_rc_lfsr7.sv | 23 ++
 rtl/keccak_rc_seq.sv | 121 ++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared types, constants and elaboration-time helpers for the Keccak
// round-constant generator.
package keccak_pkg;

   localparam logic [7:0] LFSR_POLY = 8'h71;

   typedef enum logic {ST_IDLE, ST_RUN} state_e;

   function automatic bit lane_w_legal(input int w);
      return (w == 8) || (w == 16) || (w == 32) || (w == 64);
   endfunction

   function automatic int lane_log2(input int w);
      case (w)
         8:       return 3;
         16:      return 4;
         32:      return 5;
         64:      return 6;
         default: return 0;
      endcase
   endfunction

   function automatic int nr_max(input int w);
      return 12 + 2 * lane_log2(w);
   endfunction

   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return s[7] ? ({s[6:0], 1'b0} ^ LFSR_POLY) : {s[6:0], 1'b0};
   endfunction

   // Only ever evaluated at elaboration to seed reduced-round runs.
   function automatic logic [7:0] lfsr_skip(input logic [7:0] s, input int n);
      logic [7:0] r;
      r = s;
      for (int i = 0; i < n; i++) r = lfsr_step(r);
      return r;
   endfunction

   function automatic logic [63:0] rc_expand(input logic [6:0] o, input int l);
      logic [63:0] r;
      r = '0;
      for (int j = 0; j < 7; j++) begin
         if (j <= l) r[(1 << j) - 1] = o[j];
      end
      return r;
   endfunction

endpackage

// File: rtl/keccak_rc_seq_if.sv
// Handshake and constant bus between the round controller (master) and the
// round-constant generator (slave).
interface keccak_rc_seq_if #(parameter int LANE_W = 64);

   logic              start;
   logic              advance;
   logic              abort;
   logic              rc_valid;
   logic [LANE_W-1:0] rc;
   logic [4:0]        round_idx;
   logic              last_round;
   logic              busy;
   logic              done;

   modport master (
      output start, advance, abort,
      input  rc_valid, rc, round_idx, last_round, busy, done
   );

   modport slave (
      input  start, advance, abort,
      output rc_valid, rc, round_idx, last_round, busy, done
   );

endinterface

// File: rtl/keccak_rc_lfsr7.sv
// Seven chained steps of the rc(t) LFSR: the per-round output bits and the
// LFSR state for the following round.
module keccak_rc_lfsr7
   import keccak_pkg::*;
(
   input  logic [7:0] s_i,
   output logic [6:0] o_o,
   output logic [7:0] s7_o
);

   logic [7:0] s;

   always_comb begin
      s   = s_i;
      o_o = '0;
      for (int j = 0; j < 7; j++) begin
         o_o[j] = s[0];
         s      = lfsr_step(s);
      end
      s7_o = s;
   end

endmodule

// File: rtl/keccak_rc_seq.sv
// Sequential Keccak-p round-constant generator: steps through rounds
// FIRST..NR_MAX-1 under a start/advance handshake and flags the last round.
//
// state   | meaning
// IDLE    | no permutation in progress, rc_valid low, rc/round_idx hold
// RUN     | rc/round_idx valid, waiting for advance
module keccak_rc_seq
   import keccak_pkg::*;
#(
   parameter int LANE_W     = 64,
   parameter int NUM_ROUNDS = nr_max(LANE_W)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   keccak_rc_seq_if.slave  bus
);

   localparam int         L         = lane_log2(LANE_W);
   localparam int         NRM       = nr_max(LANE_W);
   localparam int         FIRST     = NRM - NUM_ROUNDS;
   localparam logic [4:0] FIRST_IDX = 5'(FIRST);
   localparam logic [4:0] LAST_IDX  = 5'(NRM - 1);
   localparam logic [7:0] S_FIRST   = lfsr_skip(8'h01, 7 * FIRST);

   if (!lane_w_legal(LANE_W)) begin : g_bad_lane_w
      $error("keccak_rc_seq: LANE_W must be 8, 16, 32 or 64");
   end
   if (NUM_ROUNDS < 1 || NUM_ROUNDS > NRM) begin : g_bad_rounds
      $error("keccak_rc_seq: NUM_ROUNDS out of range 1..NR_MAX");
   end

   state_e            state_q, state_d;
   logic [4:0]        round_q, round_d;
   logic [7:0]        s_q, s_d;
   logic [LANE_W-1:0] rc_q, rc_d;
   logic              done_q, done_d;

   logic              last_w;
   logic [7:0]        lfsr_in;
   logic [6:0]        o_w;
   logic [7:0]        s7_w;
   logic [LANE_W-1:0] rc_new;

   assign last_w = (state_q == ST_RUN) && (round_q == LAST_IDX);

   // s_q already points at the next round; only a (re)start reloads the seed.
   assign lfsr_in = (state_q == ST_RUN && !last_w) ? s_q : S_FIRST;

   keccak_rc_lfsr7 u_lfsr7 (
      .s_i  (lfsr_in),
      .o_o  (o_w),
      .s7_o (s7_w)
   );

   assign rc_new = LANE_W'(rc_expand(o_w, L));

   always_comb begin
      state_d = state_q;
      round_d = round_q;
      s_d     = s_q;
      rc_d    = rc_q;
      done_d  = 1'b0;
      if (bus.abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  state_d = ST_RUN;
                  round_d = FIRST_IDX;
                  rc_d    = rc_new;
                  s_d     = s7_w;
               end
            end
            ST_RUN: begin
               if (bus.advance) begin
                  if (last_w) begin
                     done_d = 1'b1;
                     if (bus.start) begin
                        round_d = FIRST_IDX;
                        rc_d    = rc_new;
                        s_d     = s7_w;
                     end else begin
                        state_d = ST_IDLE;
                     end
                  end else begin
                     round_d = round_q + 5'd1;
                     rc_d    = rc_new;
                     s_d     = s7_w;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         round_q <= '0;
         s_q     <= '0;
         rc_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         s_q     <= s_d;
         rc_q    <= rc_d;
         done_q  <= done_d;
      end
   end

   assign bus.rc_valid   = (state_q == ST_RUN);
   assign bus.busy       = (state_q == ST_RUN);
   assign bus.rc         = rc_q;
   assign bus.round_idx  = round_q;
   assign bus.last_round = last_w;
   assign bus.done       = done_q;

endmodule
